// File: rtl/conv_mmio_responder.sv
// conv_mmio_responder: host-facing register/memory window for the convolution
// engine. It holds operand words and control/status registers, and buffers
// engine results so the host can read them back.
// Optional build macro: CONV_MMIO_PERF_CNT_EN adds a RUN-cycle counter that
// the host reads at the word just below the clear register.
module conv_mmio_responder #(
    parameter int ADDR_WIDTH    = 14,
    parameter int DATA_WIDTH    = 32,
    parameter int OPERAND_WORDS = 288,
    parameter int RESULT_BASE   = 'h120,
    parameter int RESULT_WORDS  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_write_addr,
    input  logic [ADDR_WIDTH-1:0] i_read_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_start,
    input  logic [8:0]            i_op_addr,
    output logic [DATA_WIDTH-1:0] o_op_data,
    input  logic                  i_res_we,
    input  logic [3:0]            i_res_addr,
    input  logic [DATA_WIDTH-1:0] i_res_data,
    input  logic                  i_done
);

    localparam int OP_AW  = $clog2(OPERAND_WORDS);
    localparam int RES_AW = $clog2(RESULT_WORDS);

    // Control registers occupy the top four words of the address space.
    localparam logic [ADDR_WIDTH-1:0] ADDR_DONE  = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_START = {{(ADDR_WIDTH-2){1'b1}}, 2'b10};
    localparam logic [ADDR_WIDTH-1:0] ADDR_CLEAR = {{(ADDR_WIDTH-2){1'b1}}, 2'b01};
`ifdef CONV_MMIO_PERF_CNT_EN
    localparam logic [ADDR_WIDTH-1:0] ADDR_PERF  = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  state;
    logic                    done_q;
    logic [RES_AW-1:0]       sweep_cnt;
    logic [DATA_WIDTH-1:0]   op_mem  [0:OPERAND_WORDS-1];
    logic [DATA_WIDTH-1:0]   res_mem [0:RESULT_WORDS-1];
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [RES_AW-1:0]       res_idx;
    logic                    in_op_rd;
    logic                    in_res_rd;
    logic                    clear_wr;
    logic                    start_wr;
    logic                    op_wr;
    logic                    can_launch;
`ifdef CONV_MMIO_PERF_CNT_EN
    logic [31:0]             perf_cnt;
`endif

    assign clear_wr   = i_we && (i_write_addr == ADDR_CLEAR) && i_data[0];
    assign start_wr   = i_we && (i_write_addr == ADDR_START) && i_data[0];
    assign can_launch = (state == S_IDLE) || (state == S_DONE);
    assign op_wr      = i_rst_n && i_we && (state != S_RUN)
                        && (i_write_addr < ADDR_WIDTH'(OPERAND_WORDS));
    assign in_op_rd   = i_read_addr < ADDR_WIDTH'(OPERAND_WORDS);
    assign in_res_rd  = (i_read_addr >= ADDR_WIDTH'(RESULT_BASE))
                        && (i_read_addr < ADDR_WIDTH'(RESULT_BASE + RESULT_WORDS));
    assign res_idx    = RES_AW'(i_read_addr - ADDR_WIDTH'(RESULT_BASE));

    // Host read decode; memory reads see pre-write contents of this cycle.
    always_comb begin
        rd_word = '0;
        if (in_op_rd) begin
            rd_word = op_mem[i_read_addr[OP_AW-1:0]];
        end else if (in_res_rd) begin
            rd_word = res_mem[res_idx];
        end else if (i_read_addr == ADDR_CLEAR) begin
            rd_word = DATA_WIDTH'(state == S_CLEAR);
        end else if (i_read_addr == ADDR_START) begin
            rd_word = DATA_WIDTH'(state == S_RUN);
        end else if (i_read_addr == ADDR_DONE) begin
            rd_word = DATA_WIDTH'(done_q);
`ifdef CONV_MMIO_PERF_CNT_EN
        end else if (i_read_addr == ADDR_PERF) begin
            rd_word = DATA_WIDTH'(perf_cnt);
`endif
        end
    end

    // Operand store: host writes, blocked while the engine is running.
    always_ff @(posedge i_clk) begin
        if (op_wr) begin
            op_mem[i_write_addr[OP_AW-1:0]] <= i_data;
        end
    end

    // Result store: zeroed by the clear sweep, written by the engine in RUN.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (state == S_CLEAR) begin
                res_mem[sweep_cnt] <= '0;
            end else if ((state == S_RUN) && i_res_we) begin
                res_mem[i_res_addr] <= i_res_data;
            end
        end
    end

    // Registered host read data, held between reads.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_data <= '0;
        end else if (i_re) begin
            o_data <= rd_word;
        end
    end

    // Registered engine operand port; out-of-range addresses return zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_op_data <= '0;
        end else if (i_op_addr < 9'(OPERAND_WORDS)) begin
            o_op_data <= op_mem[i_op_addr];
        end else begin
            o_op_data <= '0;
        end
    end

    // Control FSM: clear sweep, start pulse, completion tracking.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            done_q    <= 1'b0;
            o_start   <= 1'b0;
            sweep_cnt <= '0;
`ifdef CONV_MMIO_PERF_CNT_EN
            perf_cnt  <= '0;
`endif
        end else begin
            o_start <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (can_launch && clear_wr) begin
                        state     <= S_CLEAR;
                        sweep_cnt <= '0;
                    end else if (can_launch && start_wr) begin
                        state   <= S_RUN;
                        o_start <= 1'b1;
                        done_q  <= 1'b0;
`ifdef CONV_MMIO_PERF_CNT_EN
                        perf_cnt <= '0;
`endif
                    end
                end
                S_CLEAR: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == RES_AW'(RESULT_WORDS - 1)) begin
                        state     <= S_IDLE;
                        done_q    <= 1'b0;
                        sweep_cnt <= '0;
                    end
                end
                S_RUN: begin
`ifdef CONV_MMIO_PERF_CNT_EN
                    perf_cnt <= perf_cnt + 1'b1;
`endif
                    if (i_done) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
